// File: rtl/pulse_peak_detector_pkg.sv
// rtl/pulse_peak_detector_pkg.sv - shared widths, FSM state type and sign-widening helper for the peak detector
package pulse_peak_detector_pkg;

   localparam int SIZE_FILTER_DATA = 16;
   localparam int SIZE_TIME        = 16;
   localparam int SIZE_EVCNT       = 16;

   typedef enum logic [1:0] {IDLE, ARMED, WAIT_LOW, HOLD} peak_state_t;

   // One extra bit so threshold and hysteresis arithmetic never wraps.
   function automatic logic signed [SIZE_FILTER_DATA:0] widen(
      input logic signed [SIZE_FILTER_DATA-1:0] v
   );
      return {v[SIZE_FILTER_DATA-1], v};
   endfunction

endpackage

// File: rtl/pulse_peak_detector_peak_tracker.sv
// rtl/pulse_peak_detector_peak_tracker.sv - per-pulse max/valley/dip/pile-up tracking registers
module pulse_peak_detector_peak_tracker
   import pulse_peak_detector_pkg::*;
#(
   parameter int TIME_W = 16,
   parameter int HYST   = 20
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               clear,
   input  logic                               update,
   input  logic signed [SIZE_FILTER_DATA-1:0] sample,
   input  logic        [TIME_W-1:0]           time_now,
   output logic signed [SIZE_FILTER_DATA-1:0] max_value,
   output logic        [TIME_W-1:0]           max_time,
   output logic                               pileup
);

   localparam logic signed [SIZE_FILTER_DATA:0] HYST_X = (SIZE_FILTER_DATA+1)'(HYST);

   logic signed [SIZE_FILTER_DATA-1:0] valley;
   logic signed [SIZE_FILTER_DATA-1:0] valley_n;
   logic signed [SIZE_FILTER_DATA:0]   s_x;
   logic signed [SIZE_FILTER_DATA:0]   s_max;
   logic                               dip;
   logic                               dip_n;
   logic                               pileup_n;
   logic                               new_max;
   logic                               new_low;

   always_comb begin
      s_x      = widen(sample);
      s_max    = widen(max_value);
      new_max  = s_x > s_max;
      new_low  = s_x < widen(valley);
      // A new maximum restarts the valley search from the new top.
      valley_n = (new_max || new_low) ? sample : valley;
      dip_n    = dip || (s_x <= s_max - HYST_X);
      pileup_n = pileup || (dip_n && (s_x >= widen(valley_n) + HYST_X));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         max_value <= '0;
         max_time  <= '0;
         valley    <= '0;
         dip       <= 1'b0;
         pileup    <= 1'b0;
      end else if (clear) begin
         max_value <= sample;
         max_time  <= time_now;
         valley    <= sample;
         dip       <= 1'b0;
         pileup    <= 1'b0;
      end else if (update) begin
         if (new_max) begin
            max_value <= sample;
            max_time  <= time_now;
         end
         valley <= valley_n;
         dip    <= dip_n;
         pileup <= pileup_n;
      end
   end

endmodule

// File: rtl/pulse_peak_detector.sv
// rtl/pulse_peak_detector.sv - per-pulse peak amplitude/time event extractor for a shaped filter stream
module pulse_peak_detector
   import pulse_peak_detector_pkg::*;
#(
   parameter int SIZE_TIME  = pulse_peak_detector_pkg::SIZE_TIME,
   parameter int HYST       = 20,
   parameter int HOLDOFF    = 4,
   parameter int MAX_WIDTH  = 64,
   parameter int SIZE_EVCNT = pulse_peak_detector_pkg::SIZE_EVCNT
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
   input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
   output logic                               peak_valid,
   output logic signed [SIZE_FILTER_DATA-1:0] peak_value,
   output logic        [SIZE_TIME-1:0]        peak_time,
   output logic                               pileup,
   output logic                               overflow,
   output logic        [SIZE_EVCNT-1:0]       event_count
);

   localparam int WW = $clog2(MAX_WIDTH + 1);
   localparam int HW = $clog2(HOLDOFF + 2);

   peak_state_t                        state;
   logic        [SIZE_TIME-1:0]        time_cnt;
   logic        [WW-1:0]               width;
   logic        [HW-1:0]               hold_cnt;
   logic                               above;
   logic                               at_limit;
   logic                               hold_last;
   logic                               emit;
   logic                               trk_clear;
   logic                               trk_update;
   logic signed [SIZE_FILTER_DATA-1:0] trk_max;
   logic        [SIZE_TIME-1:0]        trk_time;
   logic                               trk_pileup;

   always_comb begin
      above      = widen(input_data) >= widen(threshold);
      at_limit   = width == WW'(MAX_WIDTH);
      hold_last  = (int'(hold_cnt) + 1) >= HOLDOFF;
      trk_clear  = (state == IDLE) && above;
      trk_update = (state == ARMED) && above && !at_limit;
      // The terminating sample never reaches the tracker, so it cannot become the peak.
      emit       = (state == ARMED) && (!above || at_limit);
   end

   pulse_peak_detector_peak_tracker #(
      .TIME_W (SIZE_TIME),
      .HYST   (HYST)
   ) u_tracker (
      .clk       (clk),
      .reset     (reset),
      .clear     (trk_clear),
      .update    (trk_update),
      .sample    (input_data),
      .time_now  (time_cnt),
      .max_value (trk_max),
      .max_time  (trk_time),
      .pileup    (trk_pileup)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         time_cnt    <= '0;
         width       <= '0;
         hold_cnt    <= '0;
         peak_valid  <= 1'b0;
         peak_value  <= '0;
         peak_time   <= '0;
         pileup      <= 1'b0;
         overflow    <= 1'b0;
         event_count <= '0;
      end else begin
         time_cnt   <= time_cnt + SIZE_TIME'(1);
         peak_valid <= emit;
         if (emit) begin
            peak_value <= trk_max;
            peak_time  <= trk_time;
            pileup     <= trk_pileup;
            overflow   <= above;
            if (event_count != '1)
               event_count <= event_count + SIZE_EVCNT'(1);
         end
         case (state)
            IDLE: begin
               if (above) begin
                  state <= ARMED;
                  width <= WW'(1);
               end
            end
            ARMED: begin
               if (!above) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
               end else if (at_limit) begin
                  state <= WAIT_LOW;
               end else begin
                  width <= width + WW'(1);
               end
            end
            WAIT_LOW: begin
               if (!above) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
               end
            end
            HOLD: begin
               if (hold_last)
                  state <= IDLE;
               else
                  hold_cnt <= hold_cnt + HW'(1);
            end
         endcase
      end
   end

endmodule
